// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared types and constants for the FIFO write-port arbiter.
// Rev    : 1.0
// ============================================================================
package fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int ARB_STAT_W = 16;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; first request strictly after
//          i_rr_ptr, searching upward modulo NREQ.
// Rev    : 1.0
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_rr_ptr,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    logic [IW-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IW'((int'(i_rr_ptr) + k) % NREQ);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_wr_arbiter
// Brief  : Round-robin burst arbiter sharing the FIFO write port between NREQ
//          requesters. Optional stats ports under FIFO_WR_ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         gnt,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*ARB_STAT_W-1:0] word_cnt,
    output logic [ARB_STAT_W-1:0]      stall_cnt
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e     r_state;
    logic [NREQ-1:0] r_gnt;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  r_rr_ptr;
    logic [CW-1:0]  r_burst_cnt;

    logic           w_pick_valid;
    logic [IW-1:0]  w_pick_idx;
    logic           w_burst;
    logic           w_own_req;
    logic           w_write;
    logic           w_last;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx)
    );

    assign w_burst   = (r_state == ARB_BURST);
    assign w_own_req = req[r_owner];
    assign w_write   = w_burst & w_own_req & ~wfull & ~wrst;
    assign w_last    = (r_burst_cnt == CW'(MAX_BURST - 1));

    assign winc  = w_write;
    assign ack   = w_write ? r_gnt : '0;
    assign gnt   = r_gnt;
    assign wdata = (w_burst & ~wrst) ? req_data[r_owner*DSIZE +: DSIZE] : '0;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state     <= ARB_IDLE;
            r_gnt       <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= IW'(NREQ - 1);
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner     <= w_pick_idx;
                        r_gnt       <= NREQ'(1) << w_pick_idx;
                        r_burst_cnt <= '0;
                        r_state     <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    // Release on a dropped request or on the final word of the burst.
                    if (!w_own_req || (w_write && w_last)) begin
                        r_rr_ptr <= r_owner;
                        r_gnt    <= '0;
                        r_state  <= ARB_IDLE;
                    end else if (w_write) begin
                        r_burst_cnt <= r_burst_cnt + CW'(1);
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [ARB_STAT_W-1:0] r_stall_cnt;

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_word_cnt
        logic [ARB_STAT_W-1:0] r_cnt;
        always_ff @(posedge wclk) begin
            if (wrst) begin
                r_cnt <= '0;
            end else if (ack[gi] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + ARB_STAT_W'(1);
            end
        end
        assign word_cnt[gi*ARB_STAT_W +: ARB_STAT_W] = r_cnt;
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_stall_cnt <= '0;
        end else if (w_burst && wfull && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + ARB_STAT_W'(1);
        end
    end
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_wr_arbiter
// Brief  : Self-checking bench for fifo_wr_arbiter (transaction-level model).
// Rev    : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int LOGN      = 256;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       gnt;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]    word_cnt;
    logic [15:0]           stall_cnt;
`endif

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .DSIZE     (DSIZE),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .gnt       (gnt),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Transaction-level model: who owns the port, words sent, last winner.
    int              m_owner;
    int              m_words;
    int              m_last;
    logic [NREQ-1:0] m_ack;

    // Requester word sources
    logic [7:0] src_data [NREQ][16];
    int         src_len  [NREQ];
    int         src_pos  [NREQ];

    // Observed write log and grant log
    int         log_req [LOGN];
    logic [7:0] log_dat [LOGN];
    int         log_cyc [LOGN];
    int         log_n = 0;
    logic [NREQ-1:0] gl [LOGN];
    int         gl_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Compare process: model prediction vs DUT every cycle, then advance model.
    initial begin : compare
        logic [NREQ-1:0]  e_gnt;
        logic             e_winc;
        logic [NREQ-1:0]  e_ack;
        logic [DSIZE-1:0] e_wdata;
        logic [NREQ-1:0]  prev_gnt;
        bit               found;
        m_owner  = -1;
        m_words  = 0;
        m_last   = NREQ - 1;
        m_ack    = '0;
        prev_gnt = '0;
        @(posedge wclk);
        forever begin
            @(negedge wclk);
            e_gnt   = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
            e_winc  = !wrst && (m_owner >= 0) && req[m_owner] && !wfull;
            e_ack   = e_winc ? e_gnt : '0;
            e_wdata = (!wrst && m_owner >= 0) ? req_data[m_owner*DSIZE +: DSIZE] : '0;
            check("gnt",   64'(gnt),   64'(e_gnt));
            check("winc",  64'(winc),  64'(e_winc));
            check("ack",   64'(ack),   64'(e_ack));
            check("wdata", 64'(wdata), 64'(e_wdata));
            if (winc === 1'b1 && log_n < LOGN) begin
                log_req[log_n] = oh2i(ack);
                log_dat[log_n] = wdata;
                log_cyc[log_n] = cyc;
                log_n++;
            end
            if (gnt != '0 && prev_gnt == '0 && gl_n < LOGN) begin
                gl[gl_n] = gnt;
                gl_n++;
            end
            prev_gnt = gnt;
            m_ack    = e_ack;
            if (wrst) begin
                m_owner = -1;
                m_last  = NREQ - 1;
                m_words = 0;
            end else if (m_owner < 0) begin
                found = 0;
                for (int j = 1; j <= NREQ; j++) begin
                    if (!found && req[(m_last + j) % NREQ]) begin
                        m_owner = (m_last + j) % NREQ;
                        found   = 1;
                    end
                end
                m_words = 0;
            end else if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (e_winc) begin
                m_words++;
                if (m_words == MAX_BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
            @(posedge wclk);
            cyc++;
        end
    end

    // Requesters: hold word until acked, then present the next one.
    initial begin : driver
        req      = '0;
        req_data = '0;
        forever begin
            @(posedge wclk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (m_ack[i]) src_pos[i]++;
                req[i] = (src_pos[i] < src_len[i]);
                req_data[i*DSIZE +: DSIZE] = req[i] ? src_data[i][src_pos[i]] : 8'h00;
            end
        end
    end

    task automatic load(input int r, input int n, input int base);
        for (int k = 0; k < n; k++) src_data[r][k] = 8'(base + k);
        src_pos[r] = 0;
        src_len[r] = n;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < NREQ; i++) if (src_pos[i] < src_len[i]) p = 1;
        return p || (m_owner >= 0);
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (pending() && t < 300) begin
            @(posedge wclk);
            #2;
            t++;
        end
        check("drain_timeout", 64'(t >= 300), 64'(0));
    endtask

    task automatic wait_writes(input int base, input int n);
        int t = 0;
        while ((log_n - base) < n && t < 100) begin
            @(posedge wclk);
            #2;
            t++;
        end
        check("write_timeout", 64'(t >= 100), 64'(0));
    endtask

    initial begin : stimulus
        int l0;
        int g0;
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        wrst  = 1'b1;
        wfull = 1'b0;

        // Reset with all requesters active
        for (int i = 0; i < NREQ; i++) load(i, 1, 8'h50 + i);
        repeat (3) begin
            @(negedge wclk);
            check("rst_gnt",  64'(gnt),  64'(0));
            check("rst_winc", 64'(winc), 64'(0));
        end
        @(posedge wclk);
        #2 wrst = 1'b0;
        wait_idle();
        check("first_grant", 64'(gl[0]), 64'(4'b0001));
        check("rst_order_3", 64'(gl[3]), 64'(4'b1000));

        // Single requester, three words
        l0 = log_n;
        load(0, 3, 8'hA0);
        wait_idle();
        check("single_count", 64'(log_n - l0), 64'(3));
        check("single_w0", 64'(log_dat[l0]),     64'(8'hA0));
        check("single_w1", 64'(log_dat[l0 + 1]), 64'(8'hA1));
        check("single_w2", 64'(log_dat[l0 + 2]), 64'(8'hA2));
        check("single_back2back", 64'(log_cyc[l0 + 2] - log_cyc[l0]), 64'(2));
        check("single_gnt_idle", 64'(gnt), 64'(0));

        // Full contention, two rounds; counters start clean
        @(posedge wclk);
        #2 wrst = 1'b1;
        @(posedge wclk);
        #2 wrst = 1'b0;
        l0 = log_n;
        g0 = gl_n;
        for (int i = 0; i < NREQ; i++) load(i, 8, 16 * (i + 1));
        wait_idle();
        check("cont_count", 64'(log_n - l0), 64'(32));
        for (int k = 0; k < 8; k++)
            check("cont_grant_order", 64'(gl[g0 + k]), 64'(NREQ'(1) << (k % NREQ)));
        for (int k = 0; k < 32; k++)
            check("cont_burst_owner", 64'(log_req[l0 + k]), 64'((k / 4) % NREQ));
        check("cont_gap", 64'(log_cyc[l0 + 4] - log_cyc[l0 + 3]), 64'(2));
        check("cont_r1_first", 64'(log_dat[l0 + 4]),  64'(8'h20));
        check("cont_r0_round2", 64'(log_dat[l0 + 16]), 64'(8'h14));
`ifdef FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check("stats_word_cnt", 64'(word_cnt[i*16 +: 16]), 64'(8));
        check("stats_stall_zero", 64'(stall_cnt), 64'(0));
`endif

        // Backpressure: wfull for three cycles after the second word
        l0 = log_n;
        load(1, 4, 8'hB0);
        wait_writes(l0, 2);
        wfull = 1'b1;
        @(negedge wclk);
        @(negedge wclk);
        check("bp_stall_gnt",  64'(gnt),  64'(4'b0010));
        check("bp_stall_winc", 64'(winc), 64'(0));
        check("bp_stall_ack",  64'(ack),  64'(0));
        repeat (2) @(posedge wclk);
        #2 wfull = 1'b0;
        wait_idle();
        check("bp_count", 64'(log_n - l0), 64'(4));
        check("bp_gap",   64'(log_cyc[l0 + 2] - log_cyc[l0 + 1]), 64'(4));
        check("bp_last",  64'(log_dat[l0 + 3]), 64'(8'hB3));
`ifdef FIFO_WR_ARB_STATS_EN
        check("stats_stall", 64'(stall_cnt), 64'(3));
`endif

        // Reset in the middle of a burst owned by requester 2
        l0 = log_n;
        g0 = gl_n;
        load(2, 4, 8'hC0);
        load(0, 4, 8'hD0);
        wait_writes(l0, 2);
        wrst = 1'b1;
        @(negedge wclk);
        check("midrst_winc", 64'(winc), 64'(0));
        @(posedge wclk);
        #2 wrst = 1'b0;
        wait_idle();
        check("midrst_first_owner", 64'(gl[g0]),     64'(4'b0100));
        check("midrst_regrant",     64'(gl[g0 + 1]), 64'(4'b0001));
        check("midrst_count",  64'(log_n - l0), 64'(8));
        check("midrst_r0_w0",  64'(log_dat[l0 + 2]), 64'(8'hD0));
        check("midrst_r2_resend", 64'(log_dat[l0 + 6]), 64'(8'hC2));

        repeat (3) @(posedge wclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
